// File: rtl/apb2_slave_regfile.sv
// APB2 completer fronting a word-addressed RW register file plus two status counters.
// It tracks the IDLE/SETUP/ACCESS bus phase and reports protocol violations.
module apb2_slave_regfile #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 8,
  parameter int unsigned           NUM_REGS   = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                           i_pclk,
  input  logic                           i_preset,
  input  logic                           i_pselx,
  input  logic                           i_penable,
  input  logic                           i_pwrite,
  input  logic [ADDR_WIDTH-1:0]          i_paddr,
  input  logic [DATA_WIDTH-1:0]          i_pwdata,
  output logic [DATA_WIDTH-1:0]          o_prdata,
  output logic [NUM_REGS*DATA_WIDTH-1:0] o_reg_out,
  output logic [NUM_REGS-1:0]            o_wr_strobe,
  output logic                           o_proto_err
);

  localparam int unsigned IdxW    = ADDR_WIDTH - 2;
  localparam int unsigned RegIdxW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [IdxW-1:0] XferIdx = IdxW'(NUM_REGS);
  localparam logic [IdxW-1:0] ErrIdx  = IdxW'(NUM_REGS + 1);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e                  r_state, w_state_next;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_write;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic                    r_legal;
  logic [DATA_WIDTH-1:0]   r_regs [NUM_REGS];
  logic [DATA_WIDTH-1:0]   r_xfer_cnt;
  logic [DATA_WIDTH-1:0]   r_err_cnt;
  logic [DATA_WIDTH-1:0]   r_prdata;
  logic [NUM_REGS-1:0]     r_wr_strobe;
  logic                    r_proto_err;

  logic                    w_violation;
  logic                    w_enter_legal;
  logic                    w_commit;
  logic [IdxW-1:0]         w_rd_idx;
  logic [IdxW-1:0]         w_wr_idx;
  logic [DATA_WIDTH-1:0]   w_rdata;
  logic [NUM_REGS-1:0]     w_strobe;
  logic [DATA_WIDTH-1:0]   w_err_base;
  logic [DATA_WIDTH-1:0]   w_err_next;

  always_comb begin
    w_state_next  = r_state;
    w_violation   = 1'b0;
    w_enter_legal = 1'b0;
    case (r_state)
      StIdle: begin
        if (i_pselx && i_penable) begin
          w_state_next = StIdle;
          w_violation  = 1'b1;
        end else if (i_pselx) begin
          w_state_next = StSetup;
        end else begin
          w_state_next = StIdle;
        end
      end
      StSetup: begin
        if (i_pselx && i_penable) begin
          w_state_next = StAccess;
          // Address/direction must hold steady from SETUP into ACCESS.
          if ((i_paddr != r_addr) || (i_pwrite != r_write)) begin
            w_violation = 1'b1;
          end else begin
            w_enter_legal = 1'b1;
          end
        end else if (i_pselx) begin
          w_state_next = StSetup;
          w_violation  = 1'b1;
        end else begin
          w_state_next = StIdle;
          w_violation  = 1'b1;
        end
      end
      StAccess: begin
        if (i_pselx && i_penable) begin
          w_state_next = StAccess;
          w_violation  = 1'b1;
        end else if (i_pselx) begin
          w_state_next = StSetup;
        end else begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign w_rd_idx = i_paddr[ADDR_WIDTH-1:2];
  assign w_wr_idx = r_addr[ADDR_WIDTH-1:2];
  assign w_commit = (r_state == StAccess) && r_legal && r_write;

  always_comb begin
    w_rdata = '0;
    if (w_rd_idx < XferIdx) begin
      w_rdata = r_regs[w_rd_idx[RegIdxW-1:0]];
    end else if (w_rd_idx == XferIdx) begin
      w_rdata = r_xfer_cnt;
    end else if (w_rd_idx == ErrIdx) begin
      w_rdata = r_err_cnt;
    end
  end

  always_comb begin
    w_strobe = '0;
    if (w_commit && (w_wr_idx < XferIdx)) begin
      w_strobe[w_wr_idx[RegIdxW-1:0]] = 1'b1;
    end
  end

  // A clear and a violation on the same edge leave the counter at one.
  assign w_err_base = (w_commit && (w_wr_idx == ErrIdx)) ? '0 : r_err_cnt;
  assign w_err_next = (w_violation && (w_err_base != '1)) ? w_err_base + DATA_WIDTH'(1)
                                                          : w_err_base;

  always_ff @(posedge i_pclk) begin
    if (i_preset) begin
      r_state     <= StIdle;
      r_addr      <= '0;
      r_write     <= 1'b0;
      r_wdata     <= '0;
      r_legal     <= 1'b0;
      r_xfer_cnt  <= '0;
      r_err_cnt   <= '0;
      r_prdata    <= '0;
      r_wr_strobe <= '0;
      r_proto_err <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= RESET_VAL;
      end
    end else begin
      r_state     <= w_state_next;
      r_proto_err <= w_violation;
      r_legal     <= w_enter_legal;
      r_wr_strobe <= w_strobe;
      r_err_cnt   <= w_err_next;
      r_prdata    <= (w_enter_legal && !i_pwrite) ? w_rdata : '0;
      if (w_state_next == StSetup) begin
        r_addr  <= i_paddr;
        r_write <= i_pwrite;
      end
      if ((r_state == StSetup) && i_pselx && i_penable) begin
        r_wdata <= i_pwdata;
      end
      if ((r_state == StAccess) && r_legal) begin
        r_xfer_cnt <= r_xfer_cnt + DATA_WIDTH'(1);
      end
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_strobe[i]) begin
          r_regs[i] <= r_wdata;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign o_reg_out[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
  end

  assign o_prdata    = r_prdata;
  assign o_wr_strobe = r_wr_strobe;
  assign o_proto_err = r_proto_err;

endmodule

// File: tb/tb_apb2_slave_regfile.sv
// Self-checking bench for apb2_slave_regfile: directed scenarios plus a randomized
// transaction stream compared against a transaction-level register-file model.
module tb_apb2_slave_regfile;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 8;
  localparam int unsigned NR = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             psel = 1'b0;
  logic             pen = 1'b0;
  logic             pwrite = 1'b0;
  logic [AW-1:0]    paddr = '0;
  logic [DW-1:0]    pwdata = '0;
  logic [DW-1:0]    prdata;
  logic [NR*DW-1:0] reg_out;
  logic [NR-1:0]    wr_strobe;
  logic             proto_err;

  int n_cmp = 0;
  int n_bad = 0;

  // Transaction-level model
  logic [DW-1:0] m_regs [NR];
  logic [DW-1:0] m_xfer;
  logic [DW-1:0] m_err;

  apb2_slave_regfile #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .NUM_REGS  (NR),
    .RESET_VAL ('0)
  ) dut (
    .i_pclk     (clk),
    .i_preset   (rst),
    .i_pselx    (psel),
    .i_penable  (pen),
    .i_pwrite   (pwrite),
    .i_paddr    (paddr),
    .i_pwdata   (pwdata),
    .o_prdata   (prdata),
    .o_reg_out  (reg_out),
    .o_wr_strobe(wr_strobe),
    .o_proto_err(proto_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    psel = 1'b0;
    pen  = 1'b0;
  endtask

  task automatic do_reset();
    go_idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Legal SETUP+ACCESS; returns prdata and proto_err seen during the ACCESS cycle.
  task automatic xfer(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      output logic [DW-1:0] rd, output logic pe);
    psel   = 1'b1;
    pen    = 1'b0;
    pwrite = wr;
    paddr  = a;
    pwdata = d;
    tick();
    pen = 1'b1;
    tick();
    rd     = prdata;
    pe     = proto_err;
    pwdata = $urandom;
    go_idle();
  endtask

  function automatic logic [DW-1:0] model_read(input int idx);
    if (idx < NR) return m_regs[idx];
    if (idx == NR) return m_xfer;
    if (idx == NR + 1) return m_err;
    return '0;
  endfunction

  task automatic test_reset();
    logic [DW-1:0] rd;
    logic          pe;
    do_reset();
    n_cmp++;
    if (prdata !== '0) begin
      n_bad++; $display("FAIL reset_prdata: got %h expected 0", prdata);
    end
    n_cmp++;
    if (wr_strobe !== '0 || proto_err !== 1'b0) begin
      n_bad++; $display("FAIL reset_pulses: got strobe=%h perr=%b expected 0/0", wr_strobe, proto_err);
    end
    n_cmp++;
    if (reg_out !== '0) begin
      n_bad++; $display("FAIL reset_regs: got %h expected all zero", reg_out);
    end
    for (int i = 0; i < NR; i++) begin
      xfer(1'b0, AW'(i * 4), '0, rd, pe);
      n_cmp++;
      if (rd !== '0 || pe !== 1'b0) begin
        n_bad++; $display("FAIL reset_read%0d: got %h perr=%b expected 0 perr=0", i, rd, pe);
      end
    end
    tick();
    xfer(1'b0, AW'(NR * 4), '0, rd, pe);
    n_cmp++;
    if (rd !== DW'(16)) begin
      n_bad++; $display("FAIL xfer_cnt_after_16: got %0d expected 16", rd);
    end
    tick();
  endtask

  task automatic test_write_read();
    logic [DW-1:0] rd;
    logic          pe;
    xfer(1'b1, 8'h08, 32'hDEADBEEF, rd, pe);
    n_cmp++;
    if (prdata !== '0) begin
      n_bad++; $display("FAIL write_prdata: got %h expected 0", prdata);
    end
    tick();
    n_cmp++;
    if (reg_out[2*DW +: DW] !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL write_reg2: got %h expected deadbeef", reg_out[2*DW +: DW]);
    end
    n_cmp++;
    if (wr_strobe !== 16'h0004) begin
      n_bad++; $display("FAIL write_strobe: got %h expected 0004", wr_strobe);
    end
    tick();
    n_cmp++;
    if (wr_strobe !== 16'h0000) begin
      n_bad++; $display("FAIL write_strobe_clear: got %h expected 0000", wr_strobe);
    end
    xfer(1'b0, 8'h08, '0, rd, pe);
    n_cmp++;
    if (rd !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL readback_reg2: got %h expected deadbeef", rd);
    end
    tick();
    n_cmp++;
    if (prdata !== '0) begin
      n_bad++; $display("FAIL prdata_after_access: got %h expected 0", prdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] rd;
    logic          pe0, pe1;
    xfer(1'b1, 8'h10, 32'h1, rd, pe0);
    xfer(1'b0, 8'h10, '0, rd, pe1);
    n_cmp++;
    if (rd !== 32'h1) begin
      n_bad++; $display("FAIL b2b_read: got %h expected 00000001", rd);
    end
    n_cmp++;
    if (pe0 !== 1'b0 || pe1 !== 1'b0) begin
      n_bad++; $display("FAIL b2b_perr: got %b%b expected 00", pe0, pe1);
    end
    tick();
    n_cmp++;
    if (proto_err !== 1'b0) begin
      n_bad++; $display("FAIL b2b_perr_end: got %b expected 0", proto_err);
    end
  endtask

  task automatic test_access_from_idle();
    logic [DW-1:0] rd;
    logic          pe;
    psel = 1'b1; pen = 1'b1; pwrite = 1'b1; paddr = 8'h04; pwdata = 32'hCAFEF00D;
    tick();
    n_cmp++;
    if (proto_err !== 1'b1) begin
      n_bad++; $display("FAIL idle_access_perr: got %b expected 1", proto_err);
    end
    go_idle();
    tick();
    n_cmp++;
    if (proto_err !== 1'b0 || wr_strobe !== '0) begin
      n_bad++; $display("FAIL idle_access_after: got perr=%b strobe=%h expected 0/0",
                        proto_err, wr_strobe);
    end
    n_cmp++;
    if (reg_out[1*DW +: DW] !== '0) begin
      n_bad++; $display("FAIL idle_access_reg1: got %h expected 0", reg_out[1*DW +: DW]);
    end
    xfer(1'b0, AW'((NR + 1) * 4), '0, rd, pe);
    n_cmp++;
    if (rd !== DW'(1)) begin
      n_bad++; $display("FAIL err_cnt_one: got %0d expected 1", rd);
    end
    tick();
  endtask

  task automatic test_addr_change();
    logic [DW-1:0] rd;
    logic          pe;
    psel = 1'b1; pen = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 32'h1234;
    tick();
    pen = 1'b1; paddr = 8'h04;
    tick();
    n_cmp++;
    if (proto_err !== 1'b1 || prdata !== '0) begin
      n_bad++; $display("FAIL addr_change_perr: got perr=%b prdata=%h expected 1/0",
                        proto_err, prdata);
    end
    go_idle();
    tick();
    n_cmp++;
    if (wr_strobe !== '0 || reg_out[0 +: 2*DW] !== '0) begin
      n_bad++; $display("FAIL addr_change_commit: got strobe=%h regs01=%h expected 0/0",
                        wr_strobe, reg_out[0 +: 2*DW]);
    end
    xfer(1'b0, AW'((NR + 1) * 4), '0, rd, pe);
    n_cmp++;
    if (rd !== DW'(2)) begin
      n_bad++; $display("FAIL err_cnt_two: got %0d expected 2", rd);
    end
    xfer(1'b1, AW'((NR + 1) * 4), 32'hFFFF_FFFF, rd, pe);
    tick();
    n_cmp++;
    if (wr_strobe !== '0) begin
      n_bad++; $display("FAIL err_clear_strobe: got %h expected 0", wr_strobe);
    end
    xfer(1'b0, AW'((NR + 1) * 4), '0, rd, pe);
    n_cmp++;
    if (rd !== '0) begin
      n_bad++; $display("FAIL err_cnt_cleared: got %0d expected 0", rd);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] rd;
    logic          pe;
    psel = 1'b1; pen = 1'b0; pwrite = 1'b1; paddr = 8'h0C; pwdata = 32'h55AA55AA;
    tick();
    pen = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    go_idle();
    n_cmp++;
    if (prdata !== '0 || wr_strobe !== '0 || proto_err !== 1'b0 || reg_out !== '0) begin
      n_bad++; $display("FAIL reset_mid_outputs: got prdata=%h strobe=%h perr=%b expected 0s",
                        prdata, wr_strobe, proto_err);
    end
    tick();
    n_cmp++;
    if (wr_strobe !== '0 || reg_out[3*DW +: DW] !== '0 || proto_err !== 1'b0) begin
      n_bad++; $display("FAIL reset_mid_commit: got strobe=%h reg3=%h perr=%b expected 0s",
                        wr_strobe, reg_out[3*DW +: DW], proto_err);
    end
    xfer(1'b0, AW'(NR * 4), '0, rd, pe);
    n_cmp++;
    if (rd !== '0 || pe !== 1'b0) begin
      n_bad++; $display("FAIL reset_mid_fsm: got xfer=%0d perr=%b expected 0/0", rd, pe);
    end
    tick();
  endtask

  task automatic test_random();
    logic [DW-1:0]    rd, d, exp_rd;
    logic [NR-1:0]    exp_strobe;
    logic [NR*DW-1:0] exp_flat;
    logic [AW-1:0]    a;
    logic             pe;
    bit               wr;
    int               idx, kind;
    do_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    m_xfer = '0;
    m_err  = '0;
    for (int it = 0; it < 300; it++) begin
      exp_strobe = '0;
      if ($urandom_range(0, 9) < 7) begin
        wr     = 1'($urandom_range(0, 1));
        idx    = $urandom_range(0, NR + 3);
        d      = $urandom;
        exp_rd = wr ? '0 : model_read(idx);
        xfer(wr, AW'(idx * 4), d, rd, pe);
        n_cmp++;
        if (rd !== exp_rd || pe !== 1'b0) begin
          n_bad++; $display("FAIL rand_access it=%0d idx=%0d wr=%0d: got %h perr=%b expected %h perr=0",
                            it, idx, wr, rd, pe, exp_rd);
        end
        m_xfer = m_xfer + 1;
        if (wr && idx < NR) begin
          m_regs[idx] = d;
          exp_strobe[idx] = 1'b1;
        end else if (wr && idx == NR + 1) begin
          m_err = '0;
        end
      end else begin
        kind = $urandom_range(0, 2);
        a    = AW'($urandom_range(0, NR - 1) * 4);
        psel = 1'b1; pwrite = 1'($urandom_range(0, 1)); paddr = a; pwdata = $urandom;
        pen  = (kind == 0);
        tick();
        if (kind == 1) begin
          go_idle();
          tick();
        end else if (kind == 2) begin
          pen   = 1'b1;
          paddr = a ^ 8'h04;
          tick();
        end
        n_cmp++;
        if (proto_err !== 1'b1 || prdata !== '0) begin
          n_bad++; $display("FAIL rand_violation it=%0d kind=%0d: got perr=%b prdata=%h expected 1/0",
                            it, kind, proto_err, prdata);
        end
        go_idle();
        if (m_err != '1) m_err = m_err + 1;
      end
      tick();
      for (int i = 0; i < NR; i++) exp_flat[i*DW +: DW] = m_regs[i];
      n_cmp++;
      if (wr_strobe !== exp_strobe || reg_out !== exp_flat || proto_err !== 1'b0) begin
        n_bad++; $display("FAIL rand_state it=%0d: got strobe=%h perr=%b expected strobe=%h perr=0",
                          it, wr_strobe, proto_err, exp_strobe);
      end
    end
    xfer(1'b0, AW'(NR * 4), '0, rd, pe);
    n_cmp++;
    if (rd !== m_xfer) begin
      n_bad++; $display("FAIL rand_xfer_cnt: got %0d expected %0d", rd, m_xfer);
    end
    m_xfer = m_xfer + 1;
    xfer(1'b0, AW'((NR + 1) * 4), '0, rd, pe);
    n_cmp++;
    if (rd !== m_err) begin
      n_bad++; $display("FAIL rand_err_cnt: got %0d expected %0d", rd, m_err);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_access_from_idle();
    test_addr_change();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
